// File: rtl/enigma_pkg.sv
// ============================================================================
// Module  : enigma_pkg
// Brief   : Shared constants, stage indices, FSM encoding and rotor helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package enigma_pkg;

    localparam int POS_W   = 5;
    localparam int ASCII_A = 65;
    localparam int ALPHA   = 26;

    localparam logic [2:0] STG_R_FWD = 3'd0;
    localparam logic [2:0] STG_M_FWD = 3'd1;
    localparam logic [2:0] STG_L_FWD = 3'd2;
    localparam logic [2:0] STG_REFL  = 3'd3;
    localparam logic [2:0] STG_L_BWD = 3'd4;
    localparam logic [2:0] STG_M_BWD = 3'd5;
    localparam logic [2:0] STG_R_BWD = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
        return (p == POS_W'(ALPHA - 1)) ? '0 : p + POS_W'(1);
    endfunction

    // Out-of-alphabet configuration values collapse to position 0.
    function automatic logic [POS_W-1:0] pos_clamp(input logic [POS_W-1:0] p);
        return (p > POS_W'(ALPHA - 1)) ? '0 : p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rotor_stepper.sv
// ============================================================================
// Module  : rotor_stepper
// Brief   : Combinational next rotor positions with notch and double-step.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rotor_stepper
    import enigma_pkg::*;
(
    input  logic [POS_W-1:0] pos_l_i,
    input  logic [POS_W-1:0] pos_m_i,
    input  logic [POS_W-1:0] pos_r_i,
    input  logic [POS_W-1:0] notch_m_i,
    input  logic [POS_W-1:0] notch_r_i,
    output logic [POS_W-1:0] pos_l_o,
    output logic [POS_W-1:0] pos_m_o,
    output logic [POS_W-1:0] pos_r_o
);

    always_comb begin
        pos_l_o = pos_l_i;
        pos_m_o = pos_m_i;
        pos_r_o = pos_inc(pos_r_i);
        // A middle rotor sitting on its notch drags itself and the left rotor.
        if (pos_m_i == notch_m_i) begin
            pos_m_o = pos_inc(pos_m_i);
            pos_l_o = pos_inc(pos_l_i);
        end else if (pos_r_i == notch_r_i) begin
            pos_m_o = pos_inc(pos_m_i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/enigma_sequencer.sv
// ============================================================================
// Module  : enigma_sequencer
// Brief   : Per-character rotor stepping and seven-stage substitution sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module enigma_sequencer
    import enigma_pkg::*;
#(
    parameter logic [4:0] NOTCH_R_DEF = 5'd16,
    parameter logic [4:0] NOTCH_M_DEF = 5'd4,
    parameter int         TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set,
    input  logic [14:0]      init_pos,
    input  logic [9:0]       notch_cfg,
    input  logic             valid,
    input  logic [7:0]       din,
    output logic             ready,
    output logic [7:0]       dout,
    output logic             done,
    output logic             err,
    output logic             stage_valid,
    output logic [2:0]       stage_sel,
    output logic             stage_dec,
    output logic [7:0]       stage_din,
    input  logic             stage_done,
    input  logic [7:0]       stage_dout,
    output logic [POS_W-1:0] pos_l,
    output logic [POS_W-1:0] pos_m,
    output logic [POS_W-1:0] pos_r
);

    state_t           state_q;
    logic [POS_W-1:0] pos_l_q, pos_m_q, pos_r_q;
    logic [POS_W-1:0] pos_l_d, pos_m_d, pos_r_d;
    logic [POS_W-1:0] notch_m_q, notch_r_q;
    logic [7:0]       char_q;
    logic [7:0]       tmo_q;
    logic             ready_q, done_q, err_q, stage_valid_q, stage_dec_q;
    logic [7:0]       dout_q, stage_din_q;
    logic [2:0]       stage_sel_q;
    logic [2:0]       next_sel;
    logic             is_letter;

    rotor_stepper u_stepper (
        .pos_l_i   (pos_l_q),
        .pos_m_i   (pos_m_q),
        .pos_r_i   (pos_r_q),
        .notch_m_i (notch_m_q),
        .notch_r_i (notch_r_q),
        .pos_l_o   (pos_l_d),
        .pos_m_o   (pos_m_d),
        .pos_r_o   (pos_r_d)
    );

    assign next_sel  = stage_sel_q + 3'd1;
    assign is_letter = (din >= 8'(ASCII_A)) && (din <= 8'(ASCII_A + ALPHA - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            pos_l_q       <= '0;
            pos_m_q       <= '0;
            pos_r_q       <= '0;
            notch_m_q     <= NOTCH_M_DEF;
            notch_r_q     <= NOTCH_R_DEF;
            char_q        <= '0;
            tmo_q         <= '0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            dout_q        <= '0;
            stage_valid_q <= 1'b0;
            stage_sel_q   <= '0;
            stage_dec_q   <= 1'b0;
            stage_din_q   <= '0;
        end else begin
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            stage_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (set) begin
                        pos_l_q   <= pos_clamp(init_pos[14:10]);
                        pos_m_q   <= pos_clamp(init_pos[9:5]);
                        pos_r_q   <= pos_clamp(init_pos[4:0]);
                        notch_m_q <= pos_clamp(notch_cfg[9:5]);
                        notch_r_q <= pos_clamp(notch_cfg[4:0]);
                    end else if (valid) begin
                        ready_q <= 1'b0;
                        if (is_letter) begin
                            char_q  <= din;
                            state_q <= S_STEP;
                        end else begin
                            dout_q  <= din;
                            done_q  <= 1'b1;
                            state_q <= S_OUT;
                        end
                    end
                end
                S_STEP: begin
                    pos_l_q       <= pos_l_d;
                    pos_m_q       <= pos_m_d;
                    pos_r_q       <= pos_r_d;
                    stage_valid_q <= 1'b1;
                    stage_sel_q   <= STG_R_FWD;
                    stage_dec_q   <= 1'b0;
                    stage_din_q   <= char_q;
                    tmo_q         <= '0;
                    state_q       <= S_ISSUE;
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (stage_done) begin
                        if (stage_sel_q == STG_R_BWD) begin
                            dout_q  <= stage_dout;
                            done_q  <= 1'b1;
                            state_q <= S_OUT;
                        end else begin
                            stage_valid_q <= 1'b1;
                            stage_sel_q   <= next_sel;
                            stage_dec_q   <= (next_sel >= STG_L_BWD);
                            stage_din_q   <= stage_dout;
                            tmo_q         <= '0;
                            state_q       <= S_ISSUE;
                        end
                    end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                        // Abandon the character; rotors keep their stepped state.
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                S_OUT: begin
                    dout_q  <= '0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready       = ready_q;
    assign dout        = dout_q;
    assign done        = done_q;
    assign err         = err_q;
    assign stage_valid = stage_valid_q;
    assign stage_sel   = stage_sel_q;
    assign stage_dec   = stage_dec_q;
    assign stage_din   = stage_din_q;
    assign pos_l       = pos_l_q;
    assign pos_m       = pos_m_q;
    assign pos_r       = pos_r_q;

endmodule

`default_nettype wire

// File: tb/tb_enigma_sequencer.sv
// ============================================================================
// Module  : tb_enigma_sequencer
// Brief   : Scoreboard bench with a behavioural rotor model and stage responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enigma_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        set = 1'b0;
    logic [14:0] init_pos = '0;
    logic [9:0]  notch_cfg = '0;
    logic        valid = 1'b0;
    logic [7:0]  din = '0;
    logic        ready, done, err, stage_valid, stage_dec;
    logic [7:0]  dout, stage_din;
    logic [2:0]  stage_sel;
    logic        stage_done = 1'b0;
    logic [7:0]  stage_dout = '0;
    logic [4:0]  pos_l, pos_m, pos_r;

    enigma_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .set         (set),
        .init_pos    (init_pos),
        .notch_cfg   (notch_cfg),
        .valid       (valid),
        .din         (din),
        .ready       (ready),
        .dout        (dout),
        .done        (done),
        .err         (err),
        .stage_valid (stage_valid),
        .stage_sel   (stage_sel),
        .stage_dec   (stage_dec),
        .stage_din   (stage_din),
        .stage_done  (stage_done),
        .stage_dout  (stage_dout),
        .pos_l       (pos_l),
        .pos_m       (pos_m),
        .pos_r       (pos_r)
    );

    always #5 clk = ~clk;

    typedef struct { int dout; int pl; int pm; int pr; int lat; int acc; } done_exp_t;
    typedef struct { int sel; int dec; int din; } stg_exp_t;

    done_exp_t done_q[$];
    stg_exp_t  stg_q[$];

    int  pass_cnt = 0;
    int  tot_cnt  = 0;
    int  cyc      = 0;
    int  stage_delay = 1;
    bit  no_resp = 1'b0;
    bit  err_expected = 1'b0;
    int  err_cyc = -1;
    int  last_acc = 0;

    // Reference rotor state
    int m_l = 0, m_m = 0, m_r = 0, m_nm = 4, m_nr = 16;

    function automatic int stage_fn(int c);
        return 65 + ((c - 65 + 1) % 26);
    endfunction

    function automatic int clamp26(int v);
        return (v > 25) ? 0 : v;
    endfunction

    task automatic chk(string name, int act, int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Stage responder: answers each request after stage_delay cycles.
    initial forever begin
        @(negedge clk);
        if (stage_valid && !no_resp && reset_n) begin
            int c;
            c = int'(stage_din);
            repeat (stage_delay) @(posedge clk);
            #1;
            stage_done = 1'b1;
            stage_dout = 8'(stage_fn(c));
            @(posedge clk);
            #1;
            stage_done = 1'b0;
            stage_dout = 8'h00;
        end
    end

    // Monitor
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            if (stage_valid) begin
                chk("stage_expected", int'(stg_q.size() > 0), 1);
                if (stg_q.size() > 0) begin
                    stg_exp_t s;
                    s = stg_q.pop_front();
                    chk("stage_sel", int'(stage_sel), s.sel);
                    chk("stage_dec", int'(stage_dec), s.dec);
                    chk("stage_din", int'(stage_din), s.din);
                end
            end
            if (done) begin
                chk("done_expected", int'(done_q.size() > 0), 1);
                if (done_q.size() > 0) begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    chk("dout", int'(dout), d.dout);
                    chk("pos_l", int'(pos_l), d.pl);
                    chk("pos_m", int'(pos_m), d.pm);
                    chk("pos_r", int'(pos_r), d.pr);
                    if (d.lat >= 0) chk("latency", cyc - d.acc, d.lat);
                end
            end
            if (err) begin
                err_cyc = cyc;
                chk("err_expected", int'(err_expected), 1);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!ready && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) chk("ready_wait", int'(ready), 1);
    endtask

    task automatic model_char(int c, bit chk_lat, bit tmo);
        done_exp_t d;
        int x;
        if (c >= 65 && c <= 90) begin
            if (m_m == m_nm) begin
                m_m = (m_m + 1) % 26;
                m_l = (m_l + 1) % 26;
            end else if (m_r == m_nr) begin
                m_m = (m_m + 1) % 26;
            end
            m_r = (m_r + 1) % 26;
            x = c;
            for (int k = 0; k < 7; k++) begin
                if (!tmo || k == 0) stg_q.push_back('{sel: k, dec: int'(k >= 4), din: x});
                x = stage_fn(x);
            end
            d = '{dout: x, pl: m_l, pm: m_m, pr: m_r, lat: chk_lat ? 15 : -1, acc: last_acc};
        end else begin
            d = '{dout: c, pl: m_l, pm: m_m, pr: m_r, lat: 0, acc: last_acc};
        end
        if (!tmo) done_q.push_back(d);
    endtask

    task automatic send(int c, int dly, bit chk_lat, bit tmo);
        wait_ready();
        stage_delay = dly;
        no_resp = tmo;
        last_acc = cyc + 1;
        valid = 1'b1;
        din = 8'(c);
        model_char(c, chk_lat, tmo);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic drive_cfg(int l, int m, int r, int nm, int nr, bit with_valid);
        wait_ready();
        set = 1'b1;
        init_pos = {5'(l), 5'(m), 5'(r)};
        notch_cfg = {5'(nm), 5'(nr)};
        valid = with_valid;
        din = 8'd65;
        m_l = clamp26(l); m_m = clamp26(m); m_r = clamp26(r);
        m_nm = clamp26(nm); m_nr = clamp26(nr);
        @(posedge clk);
        #1;
        set = 1'b0;
        valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((done_q.size() > 0 || stg_q.size() > 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("done_q_drained", done_q.size(), 0);
        chk("stg_q_drained", stg_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_stage_valid", int'(stage_valid), 0);
        chk("rst_stage_sel", int'(stage_sel), 0);
        chk("rst_stage_dec", int'(stage_dec), 0);
        chk("rst_stage_din", int'(stage_din), 0);
        chk("rst_pos", int'({pos_l, pos_m, pos_r}), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset defaults, then explicit default config
        send(65, 1, 1'b1, 1'b0);
        drive_cfg(0, 0, 0, 4, 16, 1'b0);
        send(65, 1, 1'b1, 1'b0);
        // Right-notch carry
        drive_cfg(0, 0, 16, 4, 16, 1'b0);
        send(65, 1, 1'b1, 1'b0);
        // Double step
        drive_cfg(0, 3, 16, 4, 16, 1'b0);
        send(65, 1, 1'b1, 1'b0);
        send(65, 1, 1'b1, 1'b0);
        // Wrap
        drive_cfg(25, 25, 25, 25, 25, 1'b0);
        send(65, 1, 1'b1, 1'b0);
        drain();

        // Timeout
        err_expected = 1'b1;
        err_cyc = -1;
        send(65, 1, 1'b0, 1'b1);
        n = 0;
        while (err_cyc < 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("err_seen", int'(err_cyc >= 0), 1);
        chk("err_latency", err_cyc - last_acc, 257);
        #1;
        chk("err_ready", int'(ready), 1);
        chk("err_pos_l", int'(pos_l), m_l);
        chk("err_pos_m", int'(pos_m), m_m);
        chk("err_pos_r", int'(pos_r), m_r);
        err_expected = 1'b0;
        no_resp = 1'b0;
        drain();

        // Non-letter passthrough, busy pulses, set-beats-valid
        send(48, 1, 1'b0, 1'b0);
        send(66, 1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        valid = 1'b1; din = 8'd67;
        @(posedge clk);
        #1;
        valid = 1'b0;
        set = 1'b1; init_pos = {5'd9, 5'd9, 5'd9};
        @(posedge clk);
        #1;
        set = 1'b0;
        drive_cfg(3, 4, 5, 4, 16, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("setwin_pos_l", int'(pos_l), m_l);
        chk("setwin_pos_m", int'(pos_m), m_m);
        chk("setwin_pos_r", int'(pos_r), m_r);
        drain();

        // Reset mid-character
        send(65, 1, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        done_q.delete();
        stg_q.delete();
        m_l = 0; m_m = 0; m_r = 0; m_nm = 4; m_nr = 16;
        @(negedge clk);
        chk("midrst_ready", int'(ready), 1);
        chk("midrst_done", int'(done), 0);
        chk("midrst_pos", int'({pos_l, pos_m, pos_r}), 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        send(65, 1, 1'b1, 1'b0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0)
                drive_cfg($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 31), $urandom_range(0, 31), 1'(($urandom_range(0, 1))));
            else begin
                int d;
                d = $urandom_range(1, 3);
                send($urandom_range(60, 95), d, 1'(d == 1), 1'b0);
            end
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

`default_nettype wire
